// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix load sequencer and datapath.
package matrix_pkg;

   localparam int DEFAULT_DIM    = 2;
   localparam int DEFAULT_DATA_W = 8;

   localparam logic OPERAND_A = 1'b0;
   localparam logic OPERAND_B = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_A = 3'd1,
      ST_LOAD_B = 3'd2,
      ST_START  = 3'd3,
      ST_WAIT   = 3'd4,
      ST_FIN    = 3'd5
   } state_e;

   // Index width for n elements, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/matrix_elem_counter.sv
// Modulo-N element counter with enable, clear and a wrap flag on the last step.
module matrix_elem_counter #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   input  logic         clr_i,
   output logic [W-1:0] count_o,
   output logic         wrap_o
);

   logic [W-1:0] count_q, count_d;

   assign wrap_o  = en_i && (count_q == W'(N - 1));
   assign count_o = count_q;

   always_comb begin
      count_d = count_q;
      if (clr_i || wrap_o) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/matrix_load_ctrl.sv
// Streams operand A then B into the matrix datapath, starts compute, reports done.
// Optional WAIT watchdog with err output: define MATRIX_LOAD_CTRL_TIMEOUT_EN.
module matrix_load_ctrl
   import matrix_pkg::*;
#(
   parameter int DIM    = DEFAULT_DIM,
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int IDX_W  = idx_width(DIM * DIM)
`ifdef MATRIX_LOAD_CTRL_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 255
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              go_i,
   input  logic              in_valid_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              in_ready_o,
   output logic              wr_en_o,
   output logic              wr_sel_o,
   output logic [IDX_W-1:0]  wr_addr_o,
   output logic [DATA_W-1:0] wr_data_o,
   output logic              mul_start_o,
   input  logic              mul_done_i,
   output logic              busy_o,
`ifdef MATRIX_LOAD_CTRL_TIMEOUT_EN
   output logic              err_o,
`endif
   output logic              done_o
);

   state_e             state_q;
   logic               wr_en_q, wr_sel_q, mul_start_q, busy_q, done_q;
   logic [IDX_W-1:0]   wr_addr_q;
   logic [DATA_W-1:0]  wr_data_q;
   logic               accept, cnt_clr, cnt_wrap;
   logic [IDX_W-1:0]   cnt;

`ifdef MATRIX_LOAD_CTRL_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TMO_W-1:0]   tmo_q;
   logic               err_q;
   assign err_o = err_q;
`endif

   assign in_ready_o = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
   assign accept     = in_valid_i && in_ready_o;
   assign cnt_clr    = (state_q == ST_IDLE) && go_i;

   matrix_elem_counter #(
      .N (DIM * DIM),
      .W (IDX_W)
   ) u_elem_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (accept),
      .clr_i   (cnt_clr),
      .count_o (cnt),
      .wrap_o  (cnt_wrap)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         wr_en_q     <= 1'b0;
         wr_sel_q    <= OPERAND_A;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         mul_start_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef MATRIX_LOAD_CTRL_TIMEOUT_EN
         tmo_q       <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         wr_en_q     <= accept;
         mul_start_q <= 1'b0;
         done_q      <= 1'b0;
`ifdef MATRIX_LOAD_CTRL_TIMEOUT_EN
         err_q       <= 1'b0;
`endif
         if (accept) begin
            wr_data_q <= in_data_i;
            wr_addr_q <= cnt;
            wr_sel_q  <= (state_q == ST_LOAD_B) ? OPERAND_B : OPERAND_A;
         end
         case (state_q)
            ST_IDLE: begin
               if (go_i) begin
                  state_q <= ST_LOAD_A;
                  busy_q  <= 1'b1;
               end
            end
            ST_LOAD_A: if (cnt_wrap) state_q <= ST_LOAD_B;
            ST_LOAD_B: if (cnt_wrap) state_q <= ST_START;
            ST_START: begin
               // The final B write is on the bus now; start lands right after it.
               mul_start_q <= 1'b1;
               state_q     <= ST_WAIT;
`ifdef MATRIX_LOAD_CTRL_TIMEOUT_EN
               tmo_q       <= '0;
`endif
            end
            ST_WAIT: begin
               if (mul_done_i) begin
                  state_q <= ST_FIN;
                  done_q  <= 1'b1;
`ifdef MATRIX_LOAD_CTRL_TIMEOUT_EN
               end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                  state_q <= ST_FIN;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
               end else begin
                  tmo_q   <= tmo_q + TMO_W'(1);
`endif
               end
            end
            ST_FIN: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign wr_en_o     = wr_en_q;
   assign wr_sel_o    = wr_sel_q;
   assign wr_addr_o   = wr_addr_q;
   assign wr_data_o   = wr_data_q;
   assign mul_start_o = mul_start_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule
